uart_pid_frame_ctrl: RTL

Frame controller between the UART receiver and the PID gain consumer. It sequences the PID/data byte-pair protocol and tracks per-byte completion of gains a1/a2 (8 byte slots). It enforces an inter-byte timeout and hands completed gain sets downstream over a valid/ready handshake. It replaces free-running one-cycle "ready" pulses with a held, back-pressurable output slot.

---
 rtl/uart_pid_frame_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_pid_frame_ctrl.sv
// PID/data byte-pair frame controller: assembles gains a1/a2 from UART bytes
// and presents each completed set in a held valid/ready output slot.
module uart_pid_frame_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 17,
  parameter logic [7:0]  TEST_PID       = 8'h69
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_done,
  input  logic [7:0]  rx_byte,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] a1,
  output logic [31:0] a2,
  output logic        out_test,
  output logic        err_timeout,
  output logic        err_pid,
  output logic        err_overrun,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, DATA, COMMIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [7:0]       pid, pid_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       flags, flags_nxt;
  logic [7:0][7:0]  work, work_nxt;
  logic             test_pend, test_pend_nxt;
  logic             out_valid_nxt, out_test_nxt;
  logic [31:0]      a1_nxt, a2_nxt;
  logic             err_timeout_nxt, err_pid_nxt, err_overrun_nxt;
  logic             data_pid, slot_free, load;
  logic [2:0]       idx;

  // Slots 0..3 hold a1 bytes (PID 0x10..0x13), slots 4..7 hold a2 bytes (0x20..0x23).
  assign data_pid  = (pid[7:2] == 6'b000100) || (pid[7:2] == 6'b001000);
  assign idx       = {pid[5], pid[1:0]};
  assign slot_free = !out_valid || out_ready;
  assign busy      = (state != IDLE) || (flags != 8'h00);

  always_comb begin
    state_nxt       = state;
    pid_nxt         = pid;
    cnt_nxt         = cnt;
    flags_nxt       = flags;
    work_nxt        = work;
    test_pend_nxt   = test_pend;
    out_valid_nxt   = out_valid;
    out_test_nxt    = out_test;
    a1_nxt          = a1;
    a2_nxt          = a2;
    err_timeout_nxt = 1'b0;
    err_pid_nxt     = 1'b0;
    err_overrun_nxt = 1'b0;
    load            = 1'b0;

    if (out_valid && out_ready) out_valid_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (rx_done) begin
          pid_nxt   = rx_byte;
          cnt_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (rx_done) begin
          if (data_pid) begin
            work_nxt[idx]  = rx_byte;
            flags_nxt[idx] = 1'b1;
          end else if (pid == TEST_PID) begin
            work_nxt[3]   = rx_byte;
            work_nxt[7]   = rx_byte;
            flags_nxt     = 8'hFF;
            test_pend_nxt = 1'b1;
          end else begin
            err_pid_nxt = 1'b1;
          end
          if (flags_nxt == 8'hFF) begin
            if (slot_free) begin
              load      = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = COMMIT;
            end
          end else begin
            state_nxt = IDLE;
          end
        end else if (cnt == CNT_LAST) begin
          err_timeout_nxt = 1'b1;
          state_nxt       = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      COMMIT: begin
        // Bytes arriving while a set waits for the slot are dropped, never parsed as PIDs.
        err_overrun_nxt = rx_done;
        if (slot_free) begin
          load      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load) begin
      a1_nxt        = {work_nxt[0], work_nxt[1], work_nxt[2], work_nxt[3]};
      a2_nxt        = {work_nxt[4], work_nxt[5], work_nxt[6], work_nxt[7]};
      out_valid_nxt = 1'b1;
      out_test_nxt  = test_pend_nxt;
      flags_nxt     = 8'h00;
      test_pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pid         <= 8'h00;
      cnt         <= '0;
      flags       <= 8'h00;
      work        <= '0;
      test_pend   <= 1'b0;
      out_valid   <= 1'b0;
      out_test    <= 1'b0;
      a1          <= 32'h0;
      a2          <= 32'h0;
      err_timeout <= 1'b0;
      err_pid     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_nxt;
      pid         <= pid_nxt;
      cnt         <= cnt_nxt;
      flags       <= flags_nxt;
      work        <= work_nxt;
      test_pend   <= test_pend_nxt;
      out_valid   <= out_valid_nxt;
      out_test    <= out_test_nxt;
      a1          <= a1_nxt;
      a2          <= a2_nxt;
      err_timeout <= err_timeout_nxt;
      err_pid     <= err_pid_nxt;
      err_overrun <= err_overrun_nxt;
    end
  end

endmodule
